alu_muldiv_unit: RTL and testbench



---
 rtl/alu_muldiv_unit_if.sv | 21 ++
 rtl/alu_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_unit_if.sv
// Execute-stage ALU request/response bundle: start/operands in, result/busy/done out.
interface alu_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             ALU_start;
  logic             ALU_md;
  logic [3:0]       ALU_fun;
  logic [WIDTH-1:0] ALU_srca;
  logic [WIDTH-1:0] ALU_srcb;
  logic [WIDTH-1:0] ALU_result;
  logic             ALU_busy;
  logic             ALU_done;

  modport master (
    output ALU_start, ALU_md, ALU_fun, ALU_srca, ALU_srcb,
    input  ALU_result, ALU_busy, ALU_done
  );

  modport slave (
    input  ALU_start, ALU_md, ALU_fun, ALU_srca, ALU_srcb,
    output ALU_result, ALU_busy, ALU_done
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// RV32I ALU with 1-cycle registered result plus iterative RV32M mul/div (one bit per clock).
// Define ALU_MULDIV_EN to build the M-extension FSM; otherwise M requests complete in 1 cycle with 0.
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic              CLK,
  input logic              RST,
  alu_muldiv_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0] fun,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          sh;
    a_s = a;
    b_s = b;
    sh  = b[SHW-1:0];
    case (fun)
      4'b0000: base_op = a + b;
      4'b1000: base_op = a - b;
      4'b0110: base_op = a | b;
      4'b0111: base_op = a & b;
      4'b0100: base_op = a ^ b;
      4'b0101: base_op = a >> sh;
      4'b0001: base_op = a << sh;
      4'b1101: base_op = a_s >>> sh;
      4'b0010: base_op = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'b0011: base_op = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1001: base_op = a;
      default: base_op = '0;
    endcase
  endfunction

  logic             busy;
  logic             accept;
  logic [WIDTH-1:0] result_p1;
  logic             vld_p1;

  assign accept         = bus.ALU_start & ~busy;
  assign bus.ALU_result = result_p1;
  assign bus.ALU_busy   = busy;
  assign bus.ALU_done   = vld_p1;

`ifdef ALU_MULDIV_EN
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nxt;

  // hi_q: product high half / partial remainder; lo_q: multiplier / dividend -> quotient
  logic [WIDTH-1:0]   hi_q, lo_q, mag_b_q, a_q;
  logic [2:0]         op_q;
  logic               neg_q, nega_q;
  logic [SHW-1:0]     cnt_q;
  logic [2:0]         f;
  logic               sa, sb, last, div0;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fix_res;
  logic [WIDTH:0]     add_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] prod;

  assign busy = (state != IDLE);
  assign last = (cnt_q == SHW'(WIDTH-1));
  assign div0 = (mag_b_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && bus.ALU_md) state_nxt = bus.ALU_fun[2] ? DIV : MUL;
      MUL, DIV: if (last) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    f       = bus.ALU_fun[2:0];
    sa      = bus.ALU_srca[WIDTH-1] & (f == 3'b001 || f == 3'b010 || f == 3'b100 || f == 3'b110);
    sb      = bus.ALU_srcb[WIDTH-1] & (f == 3'b001 || f == 3'b100 || f == 3'b110);
    mag_a   = sa ? -bus.ALU_srca : bus.ALU_srca;
    mag_b   = sb ? -bus.ALU_srcb : bus.ALU_srcb;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, mag_b_q};
    prod    = cond_neg2({hi_q, lo_q}, neg_q);
    quo     = cond_neg(lo_q, neg_q);
    rem     = cond_neg(hi_q, nega_q);
    // Signed overflow (min / -1) falls out of the magnitude path; only /0 needs overriding.
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = div0 ? '1 : quo;
      default:                fix_res = div0 ? a_q : rem;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mag_b_q   <= '0;
      a_q       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      nega_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (bus.ALU_md) begin
            op_q    <= f;
            a_q     <= bus.ALU_srca;
            neg_q   <= sa ^ sb;
            nega_q  <= sa;
            hi_q    <= '0;
            lo_q    <= mag_a;
            mag_b_q <= mag_b;
            cnt_q   <= '0;
          end else begin
            result_p1 <= base_op(bus.ALU_fun, bus.ALU_srca, bus.ALU_srcb);
            vld_p1    <= 1'b1;
          end
        end
        MUL: begin
          {hi_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
          cnt_q        <= cnt_q + SHW'(1);
        end
        DIV: begin
          hi_q  <= rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
          lo_q  <= {lo_q[WIDTH-2:0], ~rem_sub[WIDTH]};
          cnt_q <= cnt_q + SHW'(1);
        end
        FIX: begin
          result_p1 <= fix_res;
          vld_p1    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) result_p1 <= bus.ALU_md ? '0 : base_op(bus.ALU_fun, bus.ALU_srca, bus.ALU_srcb);
    end
  end
`endif
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomised self-checking bench for alu_muldiv_unit against a plain-arithmetic reference model.
module tb_alu_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.WIDTH(32)) bus ();
  alu_muldiv_unit #(.WIDTH(32)) dut (.CLK(clk), .RST(rst), .bus(bus));

  function automatic int exp_lat(input logic md);
`ifdef ALU_MULDIV_EN
    return md ? 33 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] model(input logic md, input logic [3:0] fun,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = b[4:0];
    if (md) begin
`ifdef ALU_MULDIV_EN
      case (fun[2:0])
        3'd0: begin p = 64'(ua * ub); return p[31:0]; end
        3'd1: begin p = 64'(sa * sb); return p[63:32]; end
        3'd2: begin p = 64'(sa * ub); return p[63:32]; end
        3'd3: begin p = 64'(ua * ub); return p[63:32]; end
        3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
        3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(ua / ub); return p[31:0]; end
        3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
        default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
      endcase
`else
      return 32'h0;
`endif
    end
    case (fun)
      4'd0:  return a + b;
      4'd8:  return a - b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd1:  return a << sh;
      4'd13: return $unsigned($signed(a) >>> sh);
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after the start edge; lat = edges after it until done is seen.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (bus.ALU_done !== 1'b1 && lat < 200) begin
      if (bus.ALU_busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.ALU_done !== 1'b1) chk("done_timeout", {31'd0, bus.ALU_done}, 32'd1);
  endtask

  task automatic drive(input logic md, input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
    bus.ALU_md   = md;
    bus.ALU_fun  = fun;
    bus.ALU_srca = a;
    bus.ALU_srcb = b;
  endtask

  task automatic do_op(input string tag, input logic md, input logic [3:0] fun,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          lat, bc;
    exp = model(md, fun, a, b);
    @(negedge clk);
    drive(md, fun, a, b);
    bus.ALU_start = 1'b1;
    @(posedge clk); #1;
    bus.ALU_start = 1'b0;
    wait_done(lat, bc);
    chk({tag, ":res"}, bus.ALU_result, exp);
    chk({tag, ":lat"}, lat, exp_lat(md));
    chk({tag, ":busy"}, bc, exp_lat(md));
    @(posedge clk); #1;
    chk({tag, ":pulse"}, {31'd0, bus.ALU_done}, 32'd0);
    chk({tag, ":hold"}, bus.ALU_result, exp);
  endtask

  logic [3:0] base_codes [12] = '{4'd0, 4'd8, 4'd6, 4'd7, 4'd4, 4'd5, 4'd1, 4'd13, 4'd2, 4'd3, 4'd9, 4'd15};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, bc, nd;
    logic [31:0] exp;
    bus.ALU_start = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:result", bus.ALU_result, 32'd0);
    chk("rst:busy", {31'd0, bus.ALU_busy}, 32'd0);
    chk("rst:done", {31'd0, bus.ALU_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle:done", {31'd0, bus.ALU_done}, 32'd0);

    // Directed base and M cases
    do_op("add_ovf", 1'b0, 4'd0, 32'h7FFFFFFF, 32'h1);
    do_op("sra", 1'b0, 4'd13, 32'h80000000, 32'd4);
    do_op("sltu", 1'b0, 4'd3, 32'd1, 32'hFFFFFFFF);
    do_op("slt", 1'b0, 4'd2, 32'hFFFFFFFF, 32'd1);
    do_op("bad_code", 1'b0, 4'd10, 32'h1234, 32'h5678);
    do_op("mulh", 1'b1, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mulhu", 1'b1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mulhsu", 1'b1, 4'd2, 32'hFFFFFFFE, 32'h80000000);
    do_op("mul", 1'b1, 4'd0, 32'd3, 32'd4);
    do_op("div", 1'b1, 4'd4, 32'hFFFFFFF9, 32'd2);
    do_op("rem", 1'b1, 4'd6, 32'hFFFFFFF9, 32'd2);
    do_op("divu0", 1'b1, 4'd5, 32'd7, 32'd0);
    do_op("rem0", 1'b1, 4'd6, 32'd5, 32'd0);
    do_op("div_s0", 1'b1, 4'd4, 32'hFFFFFFF0, 32'd0);
    do_op("div_ovf", 1'b1, 4'd4, 32'h80000000, 32'hFFFFFFFF);
    do_op("rem_ovf", 1'b1, 4'd6, 32'h80000000, 32'hFFFFFFFF);
    do_op("fun3_ign", 1'b1, 4'd13, 32'd100, 32'd7);

    // Randomised mix with boundary operands sprinkled in
    for (int i = 0; i < 40; i++) begin
      logic        md;
      logic [3:0]  fun;
      logic [31:0] a, b;
      int          sel;
      md  = $urandom_range(0, 1);
      fun = md ? 4'($urandom_range(0, 15)) : base_codes[$urandom_range(0, 11)];
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 300));
      do_op($sformatf("rnd%0d", i), md, fun, a, b);
    end

    // Back-to-back base ops: a done every cycle
    @(negedge clk);
    bus.ALU_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic [3:0]  fun;
      a   = $urandom;
      b   = $urandom;
      fun = base_codes[i * 2];
      drive(1'b0, fun, a, b);
      exp = model(1'b0, fun, a, b);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d:done", i), {31'd0, bus.ALU_done}, 32'd1);
      chk($sformatf("b2b%0d:res", i), bus.ALU_result, exp);
    end
    bus.ALU_start = 1'b0;
    @(posedge clk); #1;
    chk("b2b:end", {31'd0, bus.ALU_done}, 32'd0);

`ifdef ALU_MULDIV_EN
    // Start held during busy with changing operands, then a new start in the done cycle
    @(negedge clk);
    drive(1'b1, 4'd4, 32'hFFFFFF9C, 32'd7);
    exp = model(1'b1, 4'd4, 32'hFFFFFF9C, 32'd7);
    bus.ALU_start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    nd  = 0;
    while (bus.ALU_done !== 1'b1 && lat < 200) begin
      drive(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("held:lat", lat, 32'd33);
    chk("held:res", bus.ALU_result, exp);
    drive(1'b1, 4'd0, 32'd6, 32'd7);
    @(posedge clk); #1;
    bus.ALU_start = 1'b0;
    chk("held:single", {31'd0, bus.ALU_done}, 32'd0);
    chk("held:busy2", {31'd0, bus.ALU_busy}, 32'd1);
    wait_done(lat, bc);
    chk("next:lat", lat, 32'd33);
    chk("next:res", bus.ALU_result, 32'd42);
    @(posedge clk); #1;
`endif

    // Reset in the middle of a divide
    do_op("pre_rst", 1'b0, 4'd0, 32'd5, 32'd6);
    @(negedge clk);
    drive(1'b1, 4'd4, 32'hFFFFFFF9, 32'd2);
    bus.ALU_start = 1'b1;
    @(posedge clk); #1;
    bus.ALU_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort:result", bus.ALU_result, 32'd0);
    chk("abort:busy", {31'd0, bus.ALU_busy}, 32'd0);
    chk("abort:done", {31'd0, bus.ALU_done}, 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ALU_done === 1'b1 || bus.ALU_busy === 1'b1) nd++;
    end
    chk("abort:quiet", nd, 32'd0);
    do_op("post_rst_mul", 1'b1, 4'd0, 32'd3, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
